// File: rtl/alu_issue.sv
// alu_issue: serialized issue/writeback stage wrapped around a fixed-point ALU
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   in_valid/in_ready          instruction handshake (ready only in IDLE)
//   in_opcode/rd/rs1/rs2/imm   decoded instruction fields
//   enable_alu, opcode,
//   dataA, dataB, data_imm     ALU request bus, held stable through EXEC
//   alu_valid/zero/data        ALU response
//   wb_valid/rd/data/zero      one-cycle writeback report
//   err_illegal                one-cycle pulse on dropped opcode or timeout
//   dbg_addr/dbg_data          combinational register file read port
// Optional: define ALU_ISSUE_TIMEOUT_EN to abandon EXEC after TIMEOUT cycles
module alu_issue #(
   parameter int N       = 32,
   parameter int R_W     = 4,
   parameter int TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [3:0]     in_opcode,
   input  logic [R_W-1:0] in_rd,
   input  logic [R_W-1:0] in_rs1,
   input  logic [R_W-1:0] in_rs2,
   input  logic [N-1:0]   in_imm,
   output logic           enable_alu,
   output logic [3:0]     opcode,
   output logic [N-1:0]   dataA,
   output logic [N-1:0]   dataB,
   output logic [N-1:0]   data_imm,
   input  logic           alu_valid,
   input  logic           alu_zero,
   input  logic [N-1:0]   alu_data,
   output logic           wb_valid,
   output logic [R_W-1:0] wb_rd,
   output logic [N-1:0]   wb_data,
   output logic           wb_zero,
   output logic           err_illegal,
   input  logic [R_W-1:0] dbg_addr,
   output logic [N-1:0]   dbg_data
);
   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
   state_t state_q, state_d;
   logic [N-1:0] rf_q [2**R_W];
   logic [3:0] op_q;
   logic [R_W-1:0] rd_q, rs1_q, rs2_q;
   logic [N-1:0] imm_q;
   logic legal, expire;
   assign legal = in_opcode inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8};
`ifdef ALU_ISSUE_TIMEOUT_EN
   localparam int C_W = $clog2(TIMEOUT + 1);
   logic [C_W-1:0] cnt_q;
   // cnt_q counts completed EXEC cycles, so this is the TIMEOUT-th one
   assign expire = cnt_q == C_W'(TIMEOUT - 1);
`else
   assign expire = 1'b0;
`endif
   assign in_ready = state_q == IDLE;
   assign dbg_data = rf_q[dbg_addr];
   always_comb begin
      state_d = state_q == IDLE ? ((in_valid && legal) ? READ : IDLE)
              : state_q == READ ? EXEC
              : state_q == EXEC ? (alu_valid ? WB : (expire ? IDLE : EXEC))
              : IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         op_q        <= '0;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         imm_q       <= '0;
         enable_alu  <= 1'b0;
         opcode      <= '0;
         dataA       <= '0;
         dataB       <= '0;
         data_imm    <= '0;
         wb_valid    <= 1'b0;
         wb_rd       <= '0;
         wb_data     <= '0;
         wb_zero     <= 1'b0;
         err_illegal <= 1'b0;
         for (int i = 0; i < 2**R_W; i++) rf_q[i] <= '0;
`ifdef ALU_ISSUE_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         enable_alu  <= state_d == EXEC;
         wb_valid    <= state_q == EXEC && alu_valid;
         err_illegal <= (state_q == IDLE && in_valid && !legal) ||
                        (state_q == EXEC && !alu_valid && expire);
         if (state_q == IDLE && in_valid) begin
            op_q  <= in_opcode;
            rd_q  <= in_rd;
            rs1_q <= in_rs1;
            rs2_q <= in_rs2;
            imm_q <= in_imm;
         end
         if (state_q == READ) begin
            opcode   <= op_q;
            dataA    <= rf_q[rs1_q];
            dataB    <= rf_q[rs2_q];
            data_imm <= imm_q;
         end
         // register 0 stays zero, but the writeback is still reported
         if (state_q == EXEC && alu_valid) begin
            wb_rd   <= rd_q;
            wb_data <= alu_data;
            wb_zero <= alu_zero;
            if (rd_q != '0) rf_q[rd_q] <= alu_data;
         end
`ifdef ALU_ISSUE_TIMEOUT_EN
         cnt_q <= state_q == EXEC ? cnt_q + 1'b1 : '0;
`endif
      end
   end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue with a behavioural Q16.16 ALU
module tb_alu_issue;
   localparam int N = 32, R_W = 4, TO = 8;
   logic clk = 1'b0, rstn = 1'b0;
   logic in_valid = 1'b0, in_ready;
   logic [3:0] in_opcode = '0;
   logic [R_W-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0, dbg_addr = '0;
   logic [N-1:0] in_imm = '0;
   logic enable_alu, alu_valid, alu_zero, wb_valid, wb_zero, err_illegal;
   logic [3:0] opcode;
   logic [N-1:0] dataA, dataB, data_imm, alu_data, wb_data, dbg_data;
   logic [R_W-1:0] wb_rd;
   int vectors = 0, errs = 0, lat = 1, ecnt = 0, cyc = 0;
   typedef struct {logic [R_W-1:0] rd; logic [N-1:0] data; logic zero;} wb_t;
   wb_t sb[$];
   logic [N-1:0] model [16];

   alu_issue #(.N(N), .R_W(R_W), .TIMEOUT(TO)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_imm(in_imm), .enable_alu(enable_alu), .opcode(opcode), .dataA(dataA),
      .dataB(dataB), .data_imm(data_imm), .alu_valid(alu_valid), .alu_zero(alu_zero),
      .alu_data(alu_data), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_zero(wb_zero), .err_illegal(err_illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] alu_f(input logic [3:0] op, input logic [N-1:0] a, b, imm);
      logic [63:0] p, q;
      p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      q = (b == 0) ? '1 : 64'($signed({{16{a[31]}}, a, 16'h0}) / $signed({{32{b[31]}}, b}));
      return op == 4'd0 ? a + b : op == 4'd1 ? a + imm : op == 4'd2 ? a & b : op == 4'd3 ? a | b
           : (op == 4'd5 || op == 4'd7) ? p[47:16] : (op == 4'd6 || op == 4'd8) ? q[31:0] : '0;
   endfunction

   always_comb begin
      alu_data  = alu_f(opcode, dataA, dataB, data_imm);
      alu_zero  = alu_data == '0;
      alu_valid = enable_alu && (ecnt == lat - 1);
   end

   always @(posedge clk) begin
      ecnt <= enable_alu ? ecnt + 1 : 0;
      cyc  <= cyc + 1;
   end

   always @(negedge clk) begin
      if (wb_valid) begin
         vectors++;
         if (sb.size() == 0) begin
            errs++;
            $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", wb_rd, wb_data);
         end else begin
            wb_t e;
            e = sb.pop_front();
            if ({wb_rd, wb_data, wb_zero} !== {e.rd, e.data, e.zero}) begin
               errs++;
               $display("FAIL wb_result: got rd=%0d data=%h zero=%b, required rd=%0d data=%h zero=%b",
                        wb_rd, wb_data, wb_zero, e.rd, e.data, e.zero);
            end
         end
      end
   end

   task automatic send(input logic [3:0] op, input logic [R_W-1:0] rd, rs1, rs2,
                       input logic [N-1:0] imm, input bit push, output int t);
      int n = 0;
      wb_t e;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      if (push) begin
         e.rd = rd;
         e.data = alu_f(op, model[rs1], model[rs2], imm);
         e.zero = e.data == '0;
         sb.push_back(e);
         if (rd != 0) model[rd] = e.data;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      t = cyc;
   endtask

   task automatic wait_wb(output int k);
      k = 0;
      do begin @(negedge clk); k++; end while (!wb_valid && k < 100);
      if (!wb_valid) k = -1;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 16; i++) model[i] = '0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         dbg_addr = R_W'(i);
         #1;
         vectors++;
         if (dbg_data !== '0) begin
            errs++; $display("FAIL reset_reg%0d: got %h, required 0", i, dbg_data);
         end
      end
      vectors++;
      if ({in_ready, enable_alu, wb_valid, err_illegal, dataA, opcode} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0}) begin
         errs++;
         $display("FAIL reset_outputs: got ready=%b en=%b wb=%b err=%b dataA=%h op=%h, required 1 0 0 0 0 0",
                  in_ready, enable_alu, wb_valid, err_illegal, dataA, opcode);
      end
   endtask

   task automatic test_add;
      int t, k;
      send(4'd1, 4'd1, 4'd0, 4'd0, 32'h0003_0000, 1'b1, t); wait_wb(k);
      send(4'd1, 4'd2, 4'd0, 4'd0, 32'h0002_0000, 1'b1, t); wait_wb(k);
      send(4'd0, 4'd3, 4'd1, 4'd2, 32'h0, 1'b1, t); wait_wb(k);
      vectors++;
      if (k !== 3) begin errs++; $display("FAIL add_latency: got %0d, required 3", k); end
      vectors++;
      if (in_ready !== 1'b0) begin errs++; $display("FAIL add_ready_in_wb: got %b, required 0", in_ready); end
      @(negedge clk);
      dbg_addr = 4'd3; #1;
      vectors++;
      if ({in_ready, dbg_data} !== {1'b1, 32'h0005_0000}) begin
         errs++; $display("FAIL add_reg3: got ready=%b reg3=%h, required 1 00050000", in_ready, dbg_data);
      end
   endtask

   task automatic test_mul;
      int t, en = 0;
      bit unstable = 0;
      lat = 5;
      send(4'd5, 4'd4, 4'd1, 4'd2, 32'h0, 1'b1, t);
      for (int k = 0; k < 40 && !wb_valid; k++) begin
         @(negedge clk);
         if (enable_alu) begin
            en++;
            if ({opcode, dataA, dataB} !== {4'd5, 32'h0003_0000, 32'h0002_0000}) unstable = 1;
         end
      end
      lat = 1;
      vectors++;
      if (en !== 5) begin errs++; $display("FAIL mul_enable_cycles: got %0d, required 5", en); end
      vectors++;
      if (unstable) begin errs++; $display("FAIL mul_operands: got unstable, required stable"); end
      dbg_addr = 4'd4; #1;
      vectors++;
      if (dbg_data !== 32'h0006_0000) begin errs++; $display("FAIL mul_reg4: got %h, required 00060000", dbg_data); end
   endtask

   task automatic test_illegal;
      int t, k, errc = 0;
      bit bad = 0;
      @(negedge clk);
      send(4'hF, 4'd6, 4'd1, 4'd2, 32'h0, 1'b0, t);
      repeat (6) begin
         @(negedge clk);
         errc += int'(err_illegal);
         if (enable_alu || wb_valid || !in_ready) bad = 1;
      end
      vectors++;
      if (errc !== 1) begin errs++; $display("FAIL illegal_err_pulses: got %0d, required 1", errc); end
      vectors++;
      if (bad) begin errs++; $display("FAIL illegal_side_effects: got activity, required none"); end
      send(4'd2, 4'd5, 4'd1, 4'd0, 32'h0, 1'b1, t); wait_wb(k);
      vectors++;
      if ({k, wb_zero} !== {32'd3, 1'b1}) begin
         errs++; $display("FAIL and_zero: got k=%0d zero=%b, required k=3 zero=1", k, wb_zero);
      end
   endtask

   task automatic test_reg0;
      int t, k;
      send(4'd1, 4'd0, 4'd1, 4'd0, 32'h0000_1234, 1'b1, t); wait_wb(k);
      dbg_addr = 4'd0; #1;
      vectors++;
      if ({k, dbg_data} !== {32'd3, 32'h0}) begin
         errs++; $display("FAIL reg0_write: got k=%0d reg0=%h, required k=3 reg0=0", k, dbg_data);
      end
   endtask

   task automatic test_back_to_back;
      int t1, t2, k;
      @(negedge clk);
      send(4'd0, 4'd6, 4'd1, 4'd2, 32'h0, 1'b1, t1);
      send(4'd3, 4'd7, 4'd6, 4'd4, 32'h0, 1'b1, t2);
      wait_wb(k);
      vectors++;
      if (t2 - t1 !== 4) begin errs++; $display("FAIL b2b_spacing: got %0d, required 4", t2 - t1); end
      dbg_addr = 4'd7; #1;
      vectors++;
      if (dbg_data !== 32'h0007_0000) begin errs++; $display("FAIL b2b_reg7: got %h, required 00070000", dbg_data); end
   endtask

`ifdef ALU_ISSUE_TIMEOUT_EN
   task automatic test_timeout;
      int t, en = 0, k = 0;
      lat = 1000;
      send(4'd5, 4'd9, 4'd1, 4'd2, 32'h0, 1'b0, t);
      while (!err_illegal && k < 50) begin @(negedge clk); k++; if (enable_alu) en++; end
      repeat (4) @(negedge clk);
      vectors++;
      if ({err_illegal, en} !== {1'b0, 32'd8} || k >= 50) begin
         errs++; $display("FAIL timeout_expire: got en=%0d k=%0d, required en=8 with err pulse", en, k);
      end
      lat = 8; en = 0;
      send(4'd5, 4'd9, 4'd1, 4'd2, 32'h0, 1'b1, t);
      for (int i = 0; i < 40 && !wb_valid; i++) begin @(negedge clk); if (enable_alu) en++; end
      lat = 1;
      vectors++;
      if ({wb_valid, en} !== {1'b1, 32'd8}) begin
         errs++; $display("FAIL timeout_late_valid: got wb=%b en=%0d, required wb=1 en=8", wb_valid, en);
      end
   endtask
`endif

   task automatic test_reset_mid;
      int t, n = 0, k = 0;
      bit bad = 0;
      lat = 1000;
      @(negedge clk);
      send(4'd6, 4'd8, 4'd1, 4'd2, 32'h0, 1'b0, t);
      while (n < 3 && k < 20) begin @(negedge clk); k++; if (enable_alu) n++; end
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 16; i++) model[i] = '0;
      dbg_addr = 4'd1; #1;
      vectors++;
      if ({n, enable_alu, in_ready, wb_valid, dbg_data} !== {32'd3, 1'b0, 1'b1, 1'b0, 32'h0}) begin
         errs++;
         $display("FAIL reset_mid: got n=%0d en=%b ready=%b wb=%b reg1=%h, required 3 0 1 0 0",
                  n, enable_alu, in_ready, wb_valid, dbg_data);
      end
      repeat (6) begin @(negedge clk); if (enable_alu || wb_valid) bad = 1; end
      lat = 1;
      vectors++;
      if (bad) begin errs++; $display("FAIL reset_mid_quiet: got activity, required none"); end
   endtask

   initial begin
      test_reset;
      test_add;
      test_mul;
      test_illegal;
      test_reg0;
      test_back_to_back;
`ifdef ALU_ISSUE_TIMEOUT_EN
      test_timeout;
`endif
      test_reset_mid;
      vectors++;
      if (sb.size() !== 0) begin errs++; $display("FAIL sb_drain: got %0d pending, required 0", sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
